// File: rtl/midi_note_disp_if.sv
// Byte handshake between the MIDI UART receiver (master) and the note display parser (slave).
interface midi_note_disp_if;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic       byte_ready_out;

  modport master (output byte_in, output byte_valid_in, input byte_ready_out);
  modport slave  (input byte_in, input byte_valid_in, output byte_ready_out);
endinterface

// File: rtl/midi_note_disp.sv
// MIDI Note On/Off parser driving four hex digits (note, velocity) with per-digit strobes.
// Define MIDI_DISP_OMNI_EN to display Note messages from all 16 channels.
//
// state | meaning
// IDLE  | waiting for status byte or running-status data byte
// DATA1 | status seen, expecting first data byte (note)
// DATA2 | expecting second data byte (velocity)
// PUB   | one-cycle publish, input stalled
module midi_note_disp #(
  parameter logic [3:0] LISTEN_CH    = 4'h0,
  parameter bit         BLANK_ON_OFF = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  midi_note_disp_if.slave   bus,
  output logic [15:0]       digits_out,
  output logic [3:0]        digit_valid_out,
  output logic              note_active_out
);

  typedef enum logic [1:0] {S_IDLE, S_DATA1, S_DATA2, S_PUB} state_t;
  typedef enum logic [2:0] {RS_NONE, RS_NOTE_ON, RS_NOTE_OFF, RS_SKIP1, RS_SKIP2} rs_t;

  state_t      state_q, state_d;
  rs_t         rs_q, rs_d;
  logic [6:0]  note_q, note_d;
  logic [6:0]  vel_q, vel_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic        active_q, active_d;

  logic       ready;
  logic       xfer;
  logic [7:0] b;
  logic       ch_match;

  assign ready              = (state_q != S_PUB);
  assign bus.byte_ready_out = ready;
  assign xfer               = bus.byte_valid_in && ready;
  assign b                  = bus.byte_in;

`ifdef MIDI_DISP_OMNI_EN
  assign ch_match = 1'b1;
`else
  assign ch_match = (b[3:0] == LISTEN_CH);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rs_q     <= RS_NONE;
      note_q   <= '0;
      vel_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    note_d   = note_q;
    vel_d    = vel_q;
    digits_d = digits_q;
    valid_d  = 4'b0000;
    active_d = active_q;

    if (state_q == S_PUB) begin
      state_d = S_IDLE;
      if (rs_q == RS_NOTE_ON && vel_q != 7'd0) begin
        digits_d = {1'b0, note_q, 1'b0, vel_q};
        valid_d  = 4'b1111;
        active_d = 1'b1;
      end else if (BLANK_ON_OFF && note_q == digits_q[14:8]) begin
        digits_d[7:0] = 8'h00;
        valid_d       = 4'b0011;
        active_d      = 1'b0;
      end
    end else if (xfer) begin
      if (!b[7]) begin
        if (state_q == S_DATA2) begin
          if (rs_q == RS_NOTE_ON || rs_q == RS_NOTE_OFF) begin
            vel_d   = b[6:0];
            state_d = S_PUB;
          end else begin
            state_d = S_IDLE;
          end
        end else if (state_q == S_DATA1 || rs_q != RS_NONE) begin
          // IDLE with live running status: byte is the first data byte of a new message
          if (rs_q == RS_SKIP1) begin
            state_d = S_IDLE;
          end else begin
            note_d  = b[6:0];
            state_d = S_DATA2;
          end
        end
      end else if (b[7:3] != 5'b11111) begin
        if (b[7:4] == 4'hF) begin
          rs_d    = RS_NONE;
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA1;
          case (b[7:4])
            4'h9:       rs_d = ch_match ? RS_NOTE_ON  : RS_SKIP2;
            4'h8:       rs_d = ch_match ? RS_NOTE_OFF : RS_SKIP2;
            4'hC, 4'hD: rs_d = RS_SKIP1;
            default:    rs_d = RS_SKIP2;
          endcase
        end
      end
    end
  end

  assign digits_out      = digits_q;
  assign digit_valid_out = valid_q;
  assign note_active_out = active_q;

endmodule
